// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and constants for the multiply/divide unit
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   localparam int MD_CNT_W = 4;

   // Ops 0..3 are the multi-cycle arithmetic ops; everything with bit 2 set is single-cycle or a no-op
   function automatic logic md_is_arith(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational 64-bit mult/div result generator with write-enable
module md_calc
   import md_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        we_o
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] dq;
   logic [31:0] dr;

   assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};

   // Signed divide on magnitudes; 0x80000000 / -1 naturally yields lo=0x80000000, hi=0
   assign a_neg = (op_i == MD_DIV) & a_i[31];
   assign b_neg = (op_i == MD_DIV) & b_i[31];
   assign abs_a = a_neg ? -a_i : a_i;
   assign abs_b = b_neg ? -b_i : b_i;
   assign uq    = (b_i == 32'd0) ? 32'd0 : abs_a / abs_b;
   assign ur    = (b_i == 32'd0) ? 32'd0 : abs_a % abs_b;
   assign dq    = (a_neg ^ b_neg) ? -uq : uq;
   assign dr    = a_neg ? -ur : ur;

   always_comb begin
      hi_o = 32'd0;
      lo_o = 32'd0;
      we_o = 1'b0;
      case (op_i)
         MD_MULT: begin
            {hi_o, lo_o} = prod_s;
            we_o         = 1'b1;
         end
         MD_MULTU: begin
            {hi_o, lo_o} = prod_u;
            we_o         = 1'b1;
         end
         MD_DIV, MD_DIVU: begin
            hi_o = dr;
            lo_o = dq;
            we_o = (b_i != 32'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide sequencer owning HI/LO and the MD stall request
module mdu_ctrl
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        md_use_D,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES - 1);
   localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES - 1);

   md_state_e           state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]         hi_q, hi_d;
   logic [31:0]         lo_q, lo_d;
   logic [31:0]         hi_nxt_q, hi_nxt_d;
   logic [31:0]         lo_nxt_q, lo_nxt_d;
   logic                we_q, we_d;

   logic [31:0]         calc_hi;
   logic [31:0]         calc_lo;
   logic                calc_we;
   logic [MD_CNT_W-1:0] load;

   md_calc u_calc (
      .op_i (md_op),
      .a_i  (src_a),
      .b_i  (src_b),
      .hi_o (calc_hi),
      .lo_o (calc_lo),
      .we_o (calc_we)
   );

   assign load = md_op[1] ? DIV_LOAD : MULT_LOAD;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_nxt_d = hi_nxt_q;
      lo_nxt_d = lo_nxt_q;
      we_d     = we_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (md_is_arith(md_op)) begin
                  hi_nxt_d = calc_hi;
                  lo_nxt_d = calc_lo;
                  we_d     = calc_we;
                  // A single-cycle latency commits on the launch edge itself
                  if (load == '0) begin
                     if (calc_we) begin
                        hi_d = calc_hi;
                        lo_d = calc_lo;
                     end
                  end else begin
                     cnt_d   = load;
                     state_d = ST_BUSY;
                  end
               end else if (md_op == MD_MTHI) begin
                  hi_d = src_a;
               end else if (md_op == MD_MTLO) begin
                  lo_d = src_a;
               end
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= MD_CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (we_q) begin
                  hi_d = hi_nxt_q;
                  lo_d = lo_nxt_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         hi_nxt_q <= 32'd0;
         lo_nxt_q <= 32'd0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hi_nxt_q <= hi_nxt_d;
         lo_nxt_q <= lo_nxt_d;
         we_q     <= we_d;
      end
   end

   assign busy     = (state_q == ST_BUSY);
   assign stall_md = md_use_D & (busy | (start & md_is_arith(md_op)));
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed table-driven bench for mdu_ctrl
module tb_mdu_ctrl;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        md_use_D;
   logic        busy;
   logic        stall_md;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .md_op    (md_op),
      .src_a    (src_a),
      .src_b    (src_b),
      .md_use_D (md_use_D),
      .busy     (busy),
      .stall_md (stall_md),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          n;
   } vec_t;

   vec_t vecs[11];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
      end
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] v);
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      src_a = v;
      src_b = 32'd0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      mt(MD_MTHI, v.pre_hi);
      mt(MD_MTLO, v.pre_lo);
      #1;
      chk32($sformatf("v%0d mthi", idx), hi, v.pre_hi);
      chk32($sformatf("v%0d mtlo", idx), lo, v.pre_lo);
      chk1($sformatf("v%0d mt no busy", idx), busy, 1'b0);
      @(negedge clk);
      start = 1'b1;
      md_op = v.op;
      src_a = v.a;
      src_b = v.b;
      #1;
      chk1($sformatf("v%0d stall c0", idx), stall_md, 1'b0);
      for (int k = 1; k <= v.n; k++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         chk1($sformatf("v%0d busy c%0d", idx, k), busy, (k < v.n));
         if (k == v.n - 1) begin
            chk32($sformatf("v%0d hi held c%0d", idx, k), hi, v.pre_hi);
         end
         if (k == v.n) begin
            chk32($sformatf("v%0d hi", idx), hi, v.exp_hi);
            chk32($sformatf("v%0d lo", idx), lo, v.exp_lo);
         end
      end
   endtask

   initial begin
      vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
      vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5};
      vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3]  = '{MD_DIVU,  32'h00000005, 32'h00000000, 32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};
      vecs[4]  = '{MD_DIVU,  32'd100,      32'd7,        32'h0, 32'h0, 32'h00000002, 32'h0000000E, 10};
      vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h00000000, 32'h80000000, 10};
      vecs[6]  = '{MD_MULT,  32'h00000007, 32'hFFFFFFFD, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
      vecs[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10};
      vecs[8]  = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h9, 32'h9, 32'h00000001, 32'h00000000, 5};
      vecs[9]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0, 32'h0, 32'h0000000F, 32'h0FFFFFFF, 10};
      vecs[10] = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hAA, 32'hBB, 32'h000000AA, 32'h000000BB, 10};

      reset    = 1'b1;
      start    = 1'b0;
      md_op    = 3'd0;
      src_a    = 32'd0;
      src_b    = 32'd0;
      md_use_D = 1'b1;
      repeat (2) @(negedge clk);
      chk1("reset busy", busy, 1'b0);
      chk1("reset stall", stall_md, 1'b0);
      chk32("reset hi", hi, 32'd0);
      chk32("reset lo", lo, 32'd0);
      reset    = 1'b0;
      md_use_D = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_vec(i, vecs[i]);
      end

      // MTHI with a D-stage HI/LO user must not stall
      @(negedge clk);
      md_use_D = 1'b1;
      start    = 1'b1;
      md_op    = MD_MTHI;
      src_a    = 32'h0;
      #1;
      chk1("mthi no stall", stall_md, 1'b0);
      @(negedge clk);
      start = 1'b0;

      // Hazard path: DIV with mflo in D, stray starts while busy are ignored
      @(negedge clk);
      start = 1'b1;
      md_op = MD_DIV;
      src_a = 32'd100;
      src_b = 32'd9;
      #1;
      chk1("hz stall c0", stall_md, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 3) begin
            start = 1'b1;
            md_op = MD_MULT;
            src_a = 32'd3;
            src_b = 32'd3;
         end
         if (k == 5) begin
            start = 1'b1;
            md_op = MD_MTHI;
            src_a = 32'hDEAD;
         end
         #1;
         chk1($sformatf("hz stall c%0d", k), stall_md, (k < 10));
         if (k == 10) begin
            chk32("hz lo", lo, 32'h0000000B);
            chk32("hz hi", hi, 32'h00000001);
         end
      end
      repeat (5) @(negedge clk);
      #1;
      chk1("hz late busy", busy, 1'b0);
      chk32("hz late lo", lo, 32'h0000000B);
      chk32("hz late hi", hi, 32'h00000001);
      md_use_D = 1'b0;

      // Asynchronous reset in the middle of a MULT
      mt(MD_MTHI, 32'h5);
      mt(MD_MTLO, 32'h6);
      @(negedge clk);
      start = 1'b1;
      md_op = MD_MULT;
      src_a = 32'd3;
      src_b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      chk1("rst pre busy", busy, 1'b1);
      reset = 1'b1;
      #1;
      chk1("rst busy", busy, 1'b0);
      chk32("rst hi", hi, 32'd0);
      chk32("rst lo", lo, 32'd0);
      #1;
      reset = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      chk1("rst late busy", busy, 1'b0);
      chk32("rst late hi", hi, 32'd0);
      chk32("rst late lo", lo, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
